// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the writeback path and the write-port arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // Arbiter state: normal priority to the pipeline, or a forced slot for the B FIFO head.
    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } rfarb_state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular FIFO of pending long-latency register writes. Every slot has a valid bit,
// so a younger pipeline write can squash a queued entry in place. Squashed slots still
// occupy the ring until they reach the head, where they are released without a write.
module rf_wb_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      push_en,
    input  logic [4:0]                push_sel,
    input  logic [31:0]               push_dat,
    input  logic                      pop,
    input  logic                      squash_en,
    input  logic [4:0]                squash_sel,
    input  logic [4:0]                chk_sel1,
    input  logic [4:0]                chk_sel2,
    output logic                      head_valid,
    output logic [4:0]                head_sel,
    output logic [31:0]               head_dat,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    count_nxt,
    output logic                      hit1,
    output logic                      hit2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    used_q, used_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    regbits_t         sel_q [DEPTH];
    regbits_t         sel_d [DEPTH];
    word_t            dat_q [DEPTH];
    word_t            dat_d [DEPTH];

    logic [PW-1:0]    head_idx;
    logic [CW-1:0]    head_off;
    logic [CW-1:0]    release_n;
    logic             do_pop;
    logic             store;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    // Locate the oldest still-valid entry among the occupied slots.
    always_comb begin
        head_valid = 1'b0;
        head_off   = '0;
        head_idx   = rd_ptr_q;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((CW'(k) < used_q) && valid_q[rd_ptr_q + PW'(k)]) begin
                head_valid = 1'b1;
                head_off   = CW'(k);
                head_idx   = rd_ptr_q + PW'(k);
            end
        end
    end

    assign head_sel = sel_q[head_idx];
    assign head_dat = dat_q[head_idx];
    assign full     = (used_q == CW'(DEPTH));
    assign do_pop   = pop && head_valid;
    // Writes to r0 are accepted by the handshake but never occupy a slot.
    assign store    = push_en && !full && (push_sel != 5'd0);

    // Per-entry compare ports for the hazard unit queries.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match1[gi] = valid_q[gi] && (sel_q[gi] == chk_sel1);
            assign match2[gi] = valid_q[gi] && (sel_q[gi] == chk_sel2);
        end
    endgenerate

    assign hit1 = (chk_sel1 != 5'd0) && ((|match1) || (store && (push_sel == chk_sel1)));
    assign hit2 = (chk_sel2 != 5'd0) && ((|match2) || (store && (push_sel == chk_sel2)));

    // Next-state of the ring: squash, pop, release leading dead slots, then push.
    always_comb begin
        valid_d = valid_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && valid_q[i] && (sel_q[i] == squash_sel)) begin
                valid_d[i] = 1'b0;
            end
        end
        if (do_pop) begin
            valid_d[head_idx] = 1'b0;
        end
        if (store) begin
            valid_d[wr_ptr_q] = 1'b1;
            sel_d[wr_ptr_q]   = push_sel;
            dat_d[wr_ptr_q]   = push_dat;
        end
        // Slots ahead of the head are squashed; free them along with a popped head.
        if (do_pop) begin
            release_n = head_off + CW'(1);
        end else if (head_valid) begin
            release_n = head_off;
        end else begin
            release_n = used_q;
        end
        rd_ptr_d = rd_ptr_q + release_n[PW-1:0];
        wr_ptr_d = wr_ptr_q + PW'(store);
        used_d   = used_q - release_n + CW'(store);
    end

    // Live-entry counts now and after this cycle's updates.
    always_comb begin
        count     = '0;
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count     = count + CW'(valid_q[i]);
            count_nxt = count_nxt + CW'(valid_d[i]);
        end
    end

    // Control state; reset discards every pending entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            used_q   <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            used_q   <= used_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage; contents are meaningless unless the valid bit is set.
    always_ff @(posedge CLK) begin
        sel_q <= sel_d;
        dat_q <= dat_d;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback (A, always
// preferred) and queued long-latency results (B), forcing a one-cycle stall when the
// oldest B result has waited STARVE_LIMIT cycles.
module rf_write_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   a_wen,
    input  logic [4:0]             a_wsel,
    input  logic [31:0]            a_wdat,
    output logic                   a_stall,
    input  logic                   b_valid,
    input  logic [4:0]             b_wsel,
    input  logic [31:0]            b_wdat,
    output logic                   b_ready,
    output logic                   rf_wen,
    output logic [4:0]             rf_wsel,
    output logic [31:0]            rf_wdat,
    input  logic [4:0]             chk_sel1,
    input  logic [4:0]             chk_sel2,
    output logic                   pend1,
    output logic                   pend2,
    output logic [$clog2(DEPTH):0] b_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    rfarb_state_t  state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;

    logic          a_grant;
    logic          pop;
    logic          fifo_full;
    logic          head_valid;
    regbits_t      head_sel;
    word_t         head_dat;
    logic [CW-1:0] count_nxt;

    assign b_ready = !fifo_full;

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push_en   (b_valid && b_ready),
        .push_sel  (b_wsel),
        .push_dat  (b_wdat),
        .pop       (pop),
        .squash_en (a_grant),
        .squash_sel(a_wsel),
        .chk_sel1  (chk_sel1),
        .chk_sel2  (chk_sel2),
        .head_valid(head_valid),
        .head_sel  (head_sel),
        .head_dat  (head_dat),
        .full      (fifo_full),
        .count     (b_count),
        .count_nxt (count_nxt),
        .hit1      (pend1),
        .hit2      (pend2)
    );

    // Grant mux and next state: A first, B in idle slots, forced B slot after starvation.
    always_comb begin
        state_d = state_q;
        a_grant = 1'b0;
        pop     = 1'b0;
        a_stall = 1'b0;
        rf_wen  = 1'b0;
        rf_wsel = '0;
        rf_wdat = '0;
        case (state_q)
            NORMAL: begin
                if (a_wen && (a_wsel != 5'd0)) begin
                    a_grant = 1'b1;
                    rf_wen  = 1'b1;
                    rf_wsel = a_wsel;
                    rf_wdat = a_wdat;
                end else if (head_valid) begin
                    pop     = 1'b1;
                    rf_wen  = 1'b1;
                    rf_wsel = head_sel;
                    rf_wdat = head_dat;
                end
                // Only force a slot if something will still be queued to use it.
                if ((wait_q == WW'(STARVE_LIMIT)) && !pop && (count_nxt != '0)) begin
                    state_d = FORCE_B;
                end
            end
            FORCE_B: begin
                a_stall = 1'b1;
                pop     = head_valid;
                rf_wen  = head_valid;
                rf_wsel = head_valid ? head_sel : 5'd0;
                rf_wdat = head_valid ? head_dat : 32'd0;
                state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    // Head wait counter: counts unserved cycles, saturating at the limit.
    always_comb begin
        if (pop || (b_count == '0) || (count_nxt == '0)) begin
            wait_d = '0;
        end else if (wait_q == WW'(STARVE_LIMIT)) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + WW'(1);
        end
    end

    // FSM and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with DEPTH = 2, STARVE_LIMIT = 4.
module tb_rf_write_arbiter;

    logic        CLK;
    logic        nRST;
    logic        a_wen;
    logic [4:0]  a_wsel;
    logic [31:0] a_wdat;
    logic        a_stall;
    logic        b_valid;
    logic [4:0]  b_wsel;
    logic [31:0] b_wdat;
    logic        b_ready;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [4:0]  chk_sel1;
    logic [4:0]  chk_sel2;
    logic        pend1;
    logic        pend2;
    logic [1:0]  b_count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_arbiter #(
        .DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .a_wen   (a_wen),
        .a_wsel  (a_wsel),
        .a_wdat  (a_wdat),
        .a_stall (a_stall),
        .b_valid (b_valid),
        .b_wsel  (b_wsel),
        .b_wdat  (b_wdat),
        .b_ready (b_ready),
        .rf_wen  (rf_wen),
        .rf_wsel (rf_wsel),
        .rf_wdat (rf_wdat),
        .chk_sel1(chk_sel1),
        .chk_sel2(chk_sel2),
        .pend1   (pend1),
        .pend2   (pend2),
        .b_count (b_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic aw, input logic [4:0] asel, input logic [31:0] adat,
                          input logic bv, input logic [4:0] bsel, input logic [31:0] bdat);
        a_wen   = aw;
        a_wsel  = asel;
        a_wdat  = adat;
        b_valid = bv;
        b_wsel  = bsel;
        b_wdat  = bdat;
    endtask

    initial begin
        nRST     = 1'b0;
        chk_sel1 = 5'd0;
        chk_sel2 = 5'd0;
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        // Reset values
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_rf_wsel", 32'(rf_wsel), 32'd0);
        check("rst_rf_wdat", rf_wdat, 32'd0);
        check("rst_a_stall", 32'(a_stall), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_pend1", 32'(pend1), 32'd0);
        check("rst_pend2", 32'(pend2), 32'd0);
        check("rst_b_count", 32'(b_count), 32'd0);
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // Idle drain
        chk_sel1 = 5'd7;
        set_in(0, 0, 0, 1, 7, 32'hDEAD0007);
        #2;
        check("drain_pend_enq", 32'(pend1), 32'd1);
        check("drain_no_same_cycle", 32'(rf_wen), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("drain_wen", 32'(rf_wen), 32'd1);
        check("drain_wsel", 32'(rf_wsel), 32'd7);
        check("drain_wdat", rf_wdat, 32'hDEAD0007);
        check("drain_cnt_before", 32'(b_count), 32'd1);
        tick();
        #2;
        check("drain_cnt_after", 32'(b_count), 32'd0);
        check("drain_pend_clear", 32'(pend1), 32'd0);
        check("drain_idle", 32'(rf_wen), 32'd0);
        chk_sel1 = 5'd0;
        tick();

        // Starvation: A writes continuously, one B entry
        set_in(1, 2, 32'h100, 1, 9, 32'h9999);
        #2;
        check("starve_a_same_cycle", 32'(rf_wsel), 32'd2);
        tick();
        for (int k = 0; k <= 6; k++) begin
            set_in(1, 2, 32'h200 + 32'(k), 0, 0, 0);
            #2;
            if (k == 5) begin
                check($sformatf("starve_k%0d_stall", k), 32'(a_stall), 32'd1);
                check($sformatf("starve_k%0d_wsel", k), 32'(rf_wsel), 32'd9);
                check($sformatf("starve_k%0d_wdat", k), rf_wdat, 32'h9999);
            end else begin
                check($sformatf("starve_k%0d_stall", k), 32'(a_stall), 32'd0);
                check($sformatf("starve_k%0d_wsel", k), 32'(rf_wsel), 32'd2);
                check($sformatf("starve_k%0d_wdat", k), rf_wdat, 32'h200 + 32'(k));
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("starve_empty", 32'(b_count), 32'd0);
        tick();

        // Full FIFO, held third push
        set_in(1, 3, 32'h300, 1, 10, 32'hA0A0);
        tick();
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) set_in(1, 3, 32'h300, 1, 11, 32'hB0B0);
            else        set_in(1, 3, 32'h300, 1, 12, 32'hC0C0);
            #2;
            if (k == 0) begin
                check("full_k0_ready", 32'(b_ready), 32'd1);
                check("full_k0_cnt", 32'(b_count), 32'd1);
            end else if (k < 5) begin
                check($sformatf("full_k%0d_ready", k), 32'(b_ready), 32'd0);
                check($sformatf("full_k%0d_cnt", k), 32'(b_count), 32'd2);
            end else if (k == 5) begin
                check("full_k5_stall", 32'(a_stall), 32'd1);
                check("full_k5_wsel", 32'(rf_wsel), 32'd10);
                check("full_k5_ready", 32'(b_ready), 32'd0);
            end else begin
                check("full_k6_ready", 32'(b_ready), 32'd1);
                check("full_k6_cnt", 32'(b_count), 32'd1);
                check("full_k6_stall", 32'(a_stall), 32'd0);
                check("full_k6_wsel", 32'(rf_wsel), 32'd3);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("full_k7_cnt", 32'(b_count), 32'd2);
        check("full_k7_ready", 32'(b_ready), 32'd0);
        check("full_k7_wsel", 32'(rf_wsel), 32'd11);
        tick();
        #2;
        check("full_k8_wsel", 32'(rf_wsel), 32'd12);
        check("full_k8_wdat", rf_wdat, 32'hC0C0);
        tick();
        #2;
        check("full_k9_cnt", 32'(b_count), 32'd0);
        check("full_k9_wen", 32'(rf_wen), 32'd0);
        tick();

        // Squash
        chk_sel2 = 5'd5;
        set_in(1, 4, 32'h400, 1, 5, 32'h55);
        #2;
        check("sq_pend_enq", 32'(pend2), 32'd1);
        tick();
        set_in(1, 5, 32'h11, 0, 0, 0);
        #2;
        check("sq_pend_queued", 32'(pend2), 32'd1);
        check("sq_cnt_before", 32'(b_count), 32'd1);
        check("sq_a_wsel", 32'(rf_wsel), 32'd5);
        check("sq_a_wdat", rf_wdat, 32'h11);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("sq_cnt_after", 32'(b_count), 32'd0);
        check("sq_pend_clear", 32'(pend2), 32'd0);
        check("sq_no_b_write", 32'(rf_wen), 32'd0);
        tick();
        #2;
        check("sq_no_b_write2", 32'(rf_wen), 32'd0);
        check("sq_no_stall", 32'(a_stall), 32'd0);
        chk_sel2 = 5'd0;
        tick();

        // r0 handling
        set_in(0, 0, 0, 1, 0, 32'h123);
        #2;
        check("r0_b_ready", 32'(b_ready), 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("r0_b_not_stored", 32'(b_count), 32'd0);
        check("r0_b_no_write", 32'(rf_wen), 32'd0);
        tick();
        set_in(1, 4, 32'h44, 1, 6, 32'h66);
        tick();
        set_in(1, 0, 32'h77, 0, 0, 0);
        #2;
        check("r0_a_b_drain_wen", 32'(rf_wen), 32'd1);
        check("r0_a_b_drain_wsel", 32'(rf_wsel), 32'd6);
        check("r0_a_b_drain_wdat", rf_wdat, 32'h66);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check("r0_drained", 32'(b_count), 32'd0);
        tick();

        // Reset mid-operation while in FORCE_B with two entries
        chk_sel1 = 5'd13;
        chk_sel2 = 5'd14;
        set_in(1, 4, 32'h500, 1, 13, 32'hD);
        tick();
        set_in(1, 4, 32'h501, 1, 14, 32'hE);
        tick();
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 4, 32'h510 + 32'(k), 0, 0, 0);
            tick();
        end
        set_in(1, 4, 32'h520, 0, 0, 0);
        #2;
        check("rmid_stall", 32'(a_stall), 32'd1);
        check("rmid_wsel", 32'(rf_wsel), 32'd13);
        check("rmid_cnt", 32'(b_count), 32'd2);
        check("rmid_pend2", 32'(pend2), 32'd1);
        set_in(0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        check("rmid_rf_wen", 32'(rf_wen), 32'd0);
        check("rmid_rf_wsel", 32'(rf_wsel), 32'd0);
        check("rmid_a_stall", 32'(a_stall), 32'd0);
        check("rmid_b_count", 32'(b_count), 32'd0);
        check("rmid_b_ready", 32'(b_ready), 32'd1);
        check("rmid_pend1", 32'(pend1), 32'd0);
        check("rmid_pend2_rst", 32'(pend2), 32'd0);
        tick();
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("rpost_k%0d_wen", k), 32'(rf_wen), 32'd0);
            check($sformatf("rpost_k%0d_stall", k), 32'(a_stall), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
